// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS memory stage: write-back source select
// and the data-memory handshake state machine.
package mips_pkg;

    // Write-back source select (super_selM)
    localparam logic [1:0] SS_ALU   = 2'b00;
    localparam logic [1:0] SS_HI    = 2'b01;
    localparam logic [1:0] SS_LO    = 2'b10;
    localparam logic [1:0] SS_SHIFT = 2'b11;

    // Data-memory handshake states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair written together by a multu commit.
module hilo_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [DW-1:0] hi_d,
    input  logic [DW-1:0] lo_d,
    output logic [DW-1:0] hi_q,
    output logic [DW-1:0] lo_q
);

    // Capture both halves of the product when a multu commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-memory req/ack handshake, HI/LO commit, branch/jump
// redirect resolution and the MEM/WB pipeline register.
// Optional build macro DM_TIMEOUT_EN: abort a memory access after MAX_WAIT
// wait cycles, pulse dm_err and commit the instruction (loads write 0).
module mem_stage #(
    parameter int DW       = 32,
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validM,
    input  logic            we_dmM,
    input  logic            dm2regM,
    input  logic            we_regM,
    input  logic            jal_selM,
    input  logic            jr_selM,
    input  logic            branchM,
    input  logic            jumpM,
    input  logic            multu_enM,
    input  logic            zeroM,
    input  logic [1:0]      super_selM,
    input  logic [2*DW-1:0] alu_outM,
    input  logic [DW-1:0]   wd_dmM,
    input  logic [DW-1:0]   shiftyM,
    input  logic [DW-1:0]   pc_plus_4M,
    input  logic [DW-1:0]   btaM,
    input  logic [DW-1:0]   jtaM,
    input  logic [DW-1:0]   alu_paM,
    input  logic [RA_W-1:0] rf_waM,
    output logic            dm_req,
    output logic            dm_we,
    output logic [DW-1:0]   dm_addr,
    output logic [DW-1:0]   dm_wdata,
    input  logic            dm_ack,
    input  logic [DW-1:0]   dm_rdata,
    output logic            stall_mem,
    output logic            redir_valid,
    output logic [DW-1:0]   redir_pc,
    output logic            validW,
    output logic            we_regW,
    output logic [RA_W-1:0] rf_waW,
    output logic [DW-1:0]   wd_rfW,
    output logic [DW-1:0]   hi_q,
    output logic [DW-1:0]   lo_q,
    output logic            dm_err
);

    import mips_pkg::*;

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic          w_mem_op;
    logic          w_timeout;
    logic          w_commit;
    logic [DW-1:0] w_load_data;
    logic [DW-1:0] w_wd_next;

    // Reset is folded in so the request drops the instant rst rises, even mid-WAIT
    assign w_mem_op  = validM & (dm2regM | we_dmM) & ~rst;
    assign dm_req    = w_mem_op & ((r_state == ST_IDLE) | (r_state == ST_WAIT));
    assign dm_we     = we_dmM;
    assign dm_addr   = alu_outM[DW-1:0];
    assign dm_wdata  = wd_dmM;
    assign stall_mem = w_mem_op & ~dm_ack & ~w_timeout;
    assign w_commit  = validM & ~rst & ~stall_mem;

`ifdef DM_TIMEOUT_EN
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [CNT_W-1:0] r_wait_cnt;

    // The MAX_WAIT-th WAIT cycle without an ack aborts the access
    assign w_timeout = w_mem_op & (r_state == ST_WAIT) & ~dm_ack
                     & (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    // Count consecutive WAIT cycles; cleared whenever the FSM leaves WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT && w_state_next == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign dm_err = w_timeout;

    // An aborted load returns zero rather than whatever is on the bus
    assign w_load_data = w_timeout ? '0 : dm_rdata;

    // Handshake next state: wait only when the ack misses the request cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mem_op && !dm_ack) w_state_next = ST_WAIT;
            default: if (!w_mem_op || dm_ack || w_timeout) w_state_next = ST_IDLE;
        endcase
    end

    // Handshake state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write-back value; HI/LO reads see the values before this instruction's multu
    always_comb begin
        w_wd_next = alu_outM[DW-1:0];
        if (jal_selM) begin
            w_wd_next = pc_plus_4M;
        end else if (dm2regM) begin
            w_wd_next = w_load_data;
        end else begin
            case (super_selM)
                SS_HI:    w_wd_next = hi_q;
                SS_LO:    w_wd_next = lo_q;
                SS_SHIFT: w_wd_next = shiftyM;
                default:  w_wd_next = alu_outM[DW-1:0];
            endcase
        end
    end

    // PC redirect, only in the cycle the instruction actually commits
    always_comb begin
        redir_valid = 1'b0;
        redir_pc    = '0;
        if (w_commit) begin
            if (jr_selM) begin
                redir_valid = 1'b1;
                redir_pc    = alu_paM;
            end else if (jumpM) begin
                redir_valid = 1'b1;
                redir_pc    = jtaM;
            end else if (branchM && zeroM) begin
                redir_valid = 1'b1;
                redir_pc    = btaM;
            end
        end
    end

    // MEM/WB register: commit loads the result, otherwise insert a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validW  <= 1'b0;
            we_regW <= 1'b0;
            rf_waW  <= '0;
            wd_rfW  <= '0;
        end else if (w_commit) begin
            validW  <= 1'b1;
            we_regW <= we_regM;
            rf_waW  <= rf_waM;
            wd_rfW  <= w_wd_next;
        end else begin
            validW  <= 1'b0;
            we_regW <= 1'b0;
        end
    end

    hilo_reg #(
        .DW (DW)
    ) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we   (w_commit & multu_enM),
        .hi_d (alu_outM[2*DW-1:DW]),
        .lo_d (alu_outM[DW-1:0]),
        .hi_q (hi_q),
        .lo_q (lo_q)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes the expected MEM/WB result of
// each committing instruction; a monitor pops and compares on every validW.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        validM, we_dmM, dm2regM, we_regM, jal_selM, jr_selM;
    logic        branchM, jumpM, multu_enM, zeroM;
    logic [1:0]  super_selM;
    logic [63:0] alu_outM;
    logic [31:0] wd_dmM, shiftyM, pc_plus_4M, btaM, jtaM, alu_paM;
    logic [4:0]  rf_waM;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall_mem, redir_valid;
    logic [31:0] redir_pc;
    logic        validW, we_regW;
    logic [4:0]  rf_waW;
    logic [31:0] wd_rfW, hi_q, lo_q;
    logic        dm_err;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.DW(32), .RA_W(5), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .validM(validM), .we_dmM(we_dmM), .dm2regM(dm2regM),
        .we_regM(we_regM), .jal_selM(jal_selM), .jr_selM(jr_selM), .branchM(branchM),
        .jumpM(jumpM), .multu_enM(multu_enM), .zeroM(zeroM), .super_selM(super_selM),
        .alu_outM(alu_outM), .wd_dmM(wd_dmM), .shiftyM(shiftyM), .pc_plus_4M(pc_plus_4M),
        .btaM(btaM), .jtaM(jtaM), .alu_paM(alu_paM), .rf_waM(rf_waM),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall_mem(stall_mem),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .validW(validW),
        .we_regW(we_regW), .rf_waW(rf_waW), .wd_rfW(wd_rfW), .hi_q(hi_q),
        .lo_q(lo_q), .dm_err(dm_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        e.we = we;
        e.wa = wa;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic clear_m;
        validM = 0; we_dmM = 0; dm2regM = 0; we_regM = 0; jal_selM = 0; jr_selM = 0;
        branchM = 0; jumpM = 0; multu_enM = 0; zeroM = 0; super_selM = 2'b00;
        alu_outM = '0; wd_dmM = '0; shiftyM = '0; pc_plus_4M = '0; btaM = '0;
        jtaM = '0; alu_paM = '0; rf_waM = '0; dm_ack = 0; dm_rdata = '0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    // Monitor: every MEM/WB valid must match the oldest expected result
    always @(negedge clk) begin
        if (!rst && validW) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected actual=validW rf=%0d wd=%0h expected=no commit", rf_waW, wd_rfW);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_we_regW", 64'(we_regW), 64'(e.we));
                chk("wb_rf_waW", 64'(rf_waW), 64'(e.wa));
                chk("wb_wd_rfW", 64'(wd_rfW), 64'(e.wd));
                $display("WB rf=%0d wd=%08h we=%0d", rf_waW, wd_rfW, we_regW);
            end
        end
    end

    // Hard stop if the stimulus ever stalls out
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_m();
        repeat (2) @(posedge clk);
        mid();
        chk("rst_validW", 64'(validW), 0);
        chk("rst_we_regW", 64'(we_regW), 0);
        chk("rst_rf_waW", 64'(rf_waW), 0);
        chk("rst_wd_rfW", 64'(wd_rfW), 0);
        chk("rst_hi_q", 64'(hi_q), 0);
        chk("rst_lo_q", 64'(lo_q), 0);
        chk("rst_dm_req", 64'(dm_req), 0);
        chk("rst_dm_err", 64'(dm_err), 0);
        next_cycle();
        rst = 1'b0;

        // Load from 0x100, ack arrives after three stalled cycles
        validM = 1; dm2regM = 1; we_regM = 1; rf_waM = 5'd5; alu_outM = 64'h100;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("ld_stall", 64'(stall_mem), 1);
            chk("ld_dm_req", 64'(dm_req), 1);
            chk("ld_dm_addr", 64'(dm_addr), 64'h100);
            if (i > 0) chk("ld_bubble", 64'(we_regW), 0);
            next_cycle();
        end
        dm_ack = 1; dm_rdata = 32'hCAFE_F00D;
        push(1'b1, 5'd5, 32'hCAFE_F00D);
        mid();
        chk("ld_ack_stall", 64'(stall_mem), 0);
        chk("ld_bubble", 64'(we_regW), 0);
        $display("TX load addr=100 ack after 3 waits");
        next_cycle();

        // Store with zero-wait ack: no stall, no RF write
        clear_m();
        validM = 1; we_dmM = 1; alu_outM = 64'h200; wd_dmM = 32'h1234; dm_ack = 1; rf_waM = 5'd3;
        push(1'b0, 5'd3, 32'h200);
        mid();
        chk("st_dm_we", 64'(dm_we), 1);
        chk("st_dm_req", 64'(dm_req), 1);
        chk("st_dm_wdata", 64'(dm_wdata), 64'h1234);
        chk("st_stall", 64'(stall_mem), 0);
        $display("TX store data=1234 zero-wait");
        next_cycle();
        clear_m();
        mid();
        chk("st_dm_we_drop", 64'(dm_we), 0);
        chk("st_dm_req_drop", 64'(dm_req), 0);
        next_cycle();

        // multu, then mfhi / mflo back to back; multu+mfhi reads the old HI
        validM = 1; multu_enM = 1; alu_outM = 64'h0000_0002_0000_0003;
        push(1'b0, 5'd0, 32'h3);
        $display("TX multu 2:3");
        next_cycle();
        clear_m();
        validM = 1; we_regM = 1; rf_waM = 5'd8; super_selM = 2'b01;
        push(1'b1, 5'd8, 32'h2);
        mid();
        chk("mul_hi_q", 64'(hi_q), 64'h2);
        chk("mul_lo_q", 64'(lo_q), 64'h3);
        $display("TX mfhi");
        next_cycle();
        rf_waM = 5'd9; super_selM = 2'b10;
        push(1'b1, 5'd9, 32'h3);
        $display("TX mflo");
        next_cycle();
        rf_waM = 5'd10; super_selM = 2'b01; multu_enM = 1; alu_outM = 64'h0000_0005_0000_0007;
        push(1'b1, 5'd10, 32'h2);
        $display("TX multu+mfhi same instr");
        next_cycle();
        clear_m();
        validM = 1; we_regM = 1; rf_waM = 5'd13; super_selM = 2'b11; shiftyM = 32'hABC;
        push(1'b1, 5'd13, 32'hABC);
        mid();
        chk("mul2_hi_q", 64'(hi_q), 64'h5);
        chk("mul2_lo_q", 64'(lo_q), 64'h7);
        $display("TX shift select");
        next_cycle();
        rf_waM = 5'd14; super_selM = 2'b10;
        push(1'b1, 5'd14, 32'h7);
        $display("TX mflo after second multu");
        next_cycle();

        // Redirects: taken branch, untaken branch, jr over jump, jal
        clear_m();
        validM = 1; branchM = 1; zeroM = 1; btaM = 32'h40;
        push(1'b0, 5'd0, 32'h0);
        mid();
        chk("br_taken_valid", 64'(redir_valid), 1);
        chk("br_taken_pc", 64'(redir_pc), 64'h40);
        $display("TX branch taken");
        next_cycle();
        zeroM = 0;
        push(1'b0, 5'd0, 32'h0);
        mid();
        chk("br_nt_valid", 64'(redir_valid), 0);
        chk("br_nt_pc", 64'(redir_pc), 0);
        $display("TX branch not taken");
        next_cycle();
        clear_m();
        validM = 1; jr_selM = 1; jumpM = 1; alu_paM = 32'h80; jtaM = 32'h999;
        push(1'b0, 5'd0, 32'h0);
        mid();
        chk("jr_valid", 64'(redir_valid), 1);
        chk("jr_pc", 64'(redir_pc), 64'h80);
        $display("TX jr over jump");
        next_cycle();
        clear_m();
        validM = 1; jal_selM = 1; jumpM = 1; jtaM = 32'h300; pc_plus_4M = 32'h1004;
        we_regM = 1; rf_waM = 5'd31; alu_outM = 64'h55;
        push(1'b1, 5'd31, 32'h1004);
        mid();
        chk("jal_pc", 64'(redir_pc), 64'h300);
        $display("TX jal");
        next_cycle();

        // Load that also branches: redirect only once the load commits
        clear_m();
        validM = 1; dm2regM = 1; we_regM = 1; rf_waM = 5'd12; alu_outM = 64'h300;
        branchM = 1; zeroM = 1; btaM = 32'h60;
        mid();
        chk("ldbr_wait_redir", 64'(redir_valid), 0);
        chk("ldbr_wait_stall", 64'(stall_mem), 1);
        next_cycle();
        dm_ack = 1; dm_rdata = 32'h55;
        push(1'b1, 5'd12, 32'h55);
        mid();
        chk("ldbr_commit_redir", 64'(redir_valid), 1);
        chk("ldbr_commit_pc", 64'(redir_pc), 64'h60);
        $display("TX load+branch");
        next_cycle();

        // Invalid slot: controls set but validM low
        clear_m();
        dm2regM = 1; branchM = 1; zeroM = 1; btaM = 32'h44; we_regM = 1;
        mid();
        chk("inv_dm_req", 64'(dm_req), 0);
        chk("inv_stall", 64'(stall_mem), 0);
        chk("inv_redir", 64'(redir_valid), 0);
        next_cycle();
        clear_m();
        next_cycle();

        // Asynchronous reset while a load sits in WAIT
        validM = 1; dm2regM = 1; we_regM = 1; rf_waM = 5'd20; alu_outM = 64'h400;
        next_cycle();
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("rstw_dm_req", 64'(dm_req), 0);
        chk("rstw_stall", 64'(stall_mem), 0);
        chk("rstw_wd_rfW", 64'(wd_rfW), 0);
        chk("rstw_hi_q", 64'(hi_q), 0);
        chk("rstw_lo_q", 64'(lo_q), 0);
        chk("rstw_validW", 64'(validW), 0);
        $display("TX reset mid-WAIT");
        clear_m();
        next_cycle();
        rst = 1'b0;
        validM = 1; dm2regM = 1; we_regM = 1; rf_waM = 5'd21; alu_outM = 64'h10;
        dm_ack = 1; dm_rdata = 32'h77;
        push(1'b1, 5'd21, 32'h77);
        mid();
        chk("post_rst_stall", 64'(stall_mem), 0);
        $display("TX zero-wait load after reset");
        next_cycle();
        clear_m();

`ifdef DM_TIMEOUT_EN
        // No ack ever: abort on the 4th WAIT cycle and commit a zero load
        next_cycle();
        validM = 1; dm2regM = 1; we_regM = 1; rf_waM = 5'd22; alu_outM = 64'h500;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("to_stall", 64'(stall_mem), 1);
            chk("to_no_err", 64'(dm_err), 0);
            next_cycle();
        end
        push(1'b1, 5'd22, 32'h0);
        mid();
        chk("to_err", 64'(dm_err), 1);
        chk("to_stall_drop", 64'(stall_mem), 0);
        $display("TX load timeout");
        next_cycle();
        clear_m();
        mid();
        chk("to_err_pulse", 64'(dm_err), 0);
`endif

        repeat (3) next_cycle();
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
